// File: rtl/sevenseg_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sevenseg_scan_ctrl_pkg
//  Purpose  : Shared definitions for the seven-segment scan controller:
//             scan FSM state encoding and the all-segments-off pattern.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package sevenseg_scan_ctrl_pkg;

  // Scan FSM: anodes dark (BLANK) or one digit driven (ON)
  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_t;

  // Active-low segments {g,f,e,d,c,b,a}: all ones means every segment dark
  localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage : sevenseg_scan_ctrl_pkg
`default_nettype wire

// File: rtl/sevenseg_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : sevenseg_scan_ctrl_if
//  Purpose  : valid/ready load channel carrying a new display value from the
//             datapath (master) into the scan controller (slave).
//  Signals  : load_valid  master->slave  value present
//             load_value  master->slave  nibble i = digit i
//             load_ready  slave->master  controller can take a value
//  Revision : 1.0  initial release
// ============================================================================
interface sevenseg_scan_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  load_valid;
  logic [4*DIGITS-1:0]   load_value;
  logic                  load_ready;

  modport master (
    output load_valid,
    output load_value,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_value,
    output load_ready
  );
endinterface : sevenseg_scan_ctrl_if
`default_nettype wire

// File: rtl/sevenseg_scan_ctrl_dec.sv
`default_nettype none
// ============================================================================
//  Module   : sevenseg_scan_ctrl_dec
//  Purpose  : Combinational hex-to-seven-segment decoder, active-low outputs.
//  Ports    : nibble  in   4  hex digit 0..F
//             seg_n   out  7  active-low segments {g,f,e,d,c,b,a}
//  Revision : 1.0  initial release
// ============================================================================
module sevenseg_scan_ctrl_dec
  import sevenseg_scan_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_OFF;
    case (nibble)
      4'h0: seg_n = 7'h40;
      4'h1: seg_n = 7'h79;
      4'h2: seg_n = 7'h24;
      4'h3: seg_n = 7'h30;
      4'h4: seg_n = 7'h19;
      4'h5: seg_n = 7'h12;
      4'h6: seg_n = 7'h02;
      4'h7: seg_n = 7'h78;
      4'h8: seg_n = 7'h00;
      4'h9: seg_n = 7'h10;
      4'hA: seg_n = 7'h08;
      4'hB: seg_n = 7'h03;
      4'hC: seg_n = 7'h46;
      4'hD: seg_n = 7'h21;
      4'hE: seg_n = 7'h06;
      4'hF: seg_n = 7'h0E;
      default: seg_n = SEG_OFF;
    endcase
  end

endmodule : sevenseg_scan_ctrl_dec
`default_nettype wire

// File: rtl/sevenseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sevenseg_scan_ctrl
//  Purpose  : Time-multiplexed scan controller for a common-anode seven-
//             segment display. One shared decoder, blanking gap between
//             digits, tear-free value updates at frame boundaries.
//  Ports    : clk          in   system clock, rising edge
//             reset        in   asynchronous active-high reset
//             enable       in   1 = scan, 0 = dark and parked at BLANK/idx 0
//             blank_lz     in   1 = suppress leading zero digits
//             load_if      slave modport: load_valid/load_value/load_ready
//             anode_n      out  active-low digit enables (DIGITS bits)
//             hex_display  out  active-low segments {g,f,e,d,c,b,a}
//             frame_tick   out  one-cycle pulse at the end of each frame
//  Revision : 1.0  initial release
// ============================================================================
module sevenseg_scan_ctrl
  import sevenseg_scan_ctrl_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int ON_CYCLES    = 50000,
  parameter int BLANK_CYCLES = 100,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 blank_lz,
  sevenseg_scan_ctrl_if.slave  load_if,
  output logic [DIGITS-1:0]    anode_n,
  output logic [6:0]           hex_display,
  output logic                 frame_tick
);

  localparam int               IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int               VAL_W      = 4 * DIGITS;
  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [VAL_W-1:0]    active_q, active_d;
  logic [VAL_W-1:0]    pending_q, pending_d;
  logic                pending_full_q, pending_full_d;
  logic                load_ready_q, load_ready_d;
  logic [DIGITS-1:0]   anode_n_q, anode_n_d;
  logic [6:0]          hex_display_q, hex_display_d;
  logic                frame_tick_q, frame_tick_d;

  logic [3:0]          digit_nibble;
  logic [6:0]          seg_raw;
  logic [DIGITS-1:0]   upper_zero;
  logic                digit_blank;
  logic                dwell_done;
  logic                frame_end;
  logic                accept;
  logic                xfer;

  // upper_zero[i]: nibbles DIGITS-1 down to i of the shown value are all 0
  for (genvar i = 0; i < DIGITS; i++) begin : g_lz
    assign upper_zero[i] = (active_q[VAL_W-1:4*i] == '0);
  end

  assign digit_nibble = active_q[{idx_q, 2'b00} +: 4];

  sevenseg_scan_ctrl_dec u_dec (
    .nibble (digit_nibble),
    .seg_n  (seg_raw)
  );

  // Digit 0 is exempt so that a value of zero still shows one "0"
  assign digit_blank = blank_lz && (idx_q != '0) && upper_zero[idx_q];

  always_comb begin
    dwell_done = (state_q == ST_ON) ? (cnt_q == ON_LAST) : (cnt_q == BLANK_LAST);
    frame_end  = enable && (state_q == ST_ON) && dwell_done && (idx_q == IDX_LAST);
    // ready is only high while pending is empty, so accept never overwrites
    accept     = load_if.load_valid && load_ready_q;
    // Transfer uses the pending content from before this edge: a value
    // accepted on the frame-end edge waits a full extra frame (no bypass)
    xfer       = frame_end && pending_full_q;

    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + 1'b1;
    if (!enable) begin
      state_d = ST_BLANK;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (dwell_done) begin
      cnt_d = '0;
      if (state_q == ST_ON) begin
        state_d = ST_BLANK;
        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        state_d = ST_ON;
      end
    end

    active_d       = xfer ? pending_q : active_q;
    pending_d      = accept ? load_if.load_value : pending_q;
    pending_full_d = accept ? 1'b1 : (xfer ? 1'b0 : pending_full_q);
    // Held low through the frame_tick cycle; reopens one cycle after transfer
    load_ready_d   = ~pending_full_d & ~xfer;
    frame_tick_d   = frame_end;

    // Pins are computed from the current state and registered, so every
    // digit change passes through an all-dark BLANK state on the pins
    anode_n_d     = '1;
    hex_display_d = SEG_OFF;
    if (enable && (state_q == ST_ON)) begin
      anode_n_d     = ~(DIGITS'(1) << idx_q);
      hex_display_d = digit_blank ? SEG_OFF : seg_raw;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_BLANK;
      idx_q          <= '0;
      cnt_q          <= '0;
      active_q       <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      load_ready_q   <= 1'b1;
      anode_n_q      <= '1;
      hex_display_q  <= SEG_OFF;
      frame_tick_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      load_ready_q   <= load_ready_d;
      anode_n_q      <= anode_n_d;
      hex_display_q  <= hex_display_d;
      frame_tick_q   <= frame_tick_d;
    end
  end

  assign load_if.load_ready = load_ready_q;
  assign anode_n            = anode_n_q;
  assign hex_display        = hex_display_q;
  assign frame_tick         = frame_tick_q;

endmodule : sevenseg_scan_ctrl
`default_nettype wire

// File: tb/tb_sevenseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sevenseg_scan_ctrl
//  Purpose  : Self-checking bench for sevenseg_scan_ctrl with DIGITS=4,
//             ON_CYCLES=4, BLANK_CYCLES=2 (24-cycle frames).
//  Timing   : n counts rising edges since the scan last started (reset
//             release or re-enable). After edge n, digit d of the frame
//             based at T (a multiple of 24) is lit for n = T+3+6d .. T+6+6d,
//             and frame_tick is high exactly when n is a multiple of 24.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sevenseg_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int FRAME  = 24;

  typedef struct {
    logic [15:0]     value;
    logic            blz;
    logic [3:0][6:0] segs;   // expected segments, index = digit
  } vec_t;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        blank_lz;
  logic [3:0]  anode_n;
  logic [6:0]  hex_display;
  logic        frame_tick;

  int checks   = 0;
  int failures = 0;
  int n        = 0;
  bit ft_track = 0;

  sevenseg_scan_ctrl_if #(.DIGITS(DIGITS)) load_if ();

  sevenseg_scan_ctrl #(
    .DIGITS       (DIGITS),
    .ON_CYCLES    (4),
    .BLANK_CYCLES (2),
    .CNT_W        (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .blank_lz    (blank_lz),
    .load_if     (load_if),
    .anode_n     (anode_n),
    .hex_display (hex_display),
    .frame_tick  (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired at n=%0d", n);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s n=%0d actual=%0h required=%0h", name, n, act, exp);
    end
  endtask

  // One clock; sample #1 after the edge and check the per-cycle invariants
  task automatic step();
    @(posedge clk);
    #1;
    n++;
    check("anode_onehot", ($countones(~anode_n) <= 1) ? 32'd1 : 32'd0, 32'd1);
    if (ft_track)
      check("frame_tick", {31'd0, frame_tick}, ((n % FRAME) == 0) ? 32'd1 : 32'd0);
  endtask

  task automatic wait_until(input int target);
    if (n > target) check("schedule", n, target);
    while (n < target) step();
  endtask

  // Present v until accepted; e = edge count of the accepting edge
  task automatic load(input logic [15:0] v, output int e);
    int guard;
    guard = 0;
    load_if.load_value = v;
    load_if.load_valid = 1'b1;
    while (load_if.load_ready !== 1'b1 && guard < 200) begin
      step();
      guard++;
    end
    if (guard >= 200) check("load_timeout", 32'd0, 32'd1);
    step();
    e = n;
    load_if.load_valid = 1'b0;
    check("ready_low_after_accept", {31'd0, load_if.load_ready}, 32'd0);
  endtask

  // Walk every cycle of the frame based at T: 2 dark, 4 lit per digit
  task automatic check_frame(input int t, input logic [3:0][6:0] segs);
    for (int d = 0; d < DIGITS; d++) begin
      for (int p = 0; p < 6; p++) begin
        wait_until(t + 1 + 6 * d + p);
        if (p >= 2) begin
          check("frame_anode", {28'd0, anode_n}, {28'd0, ~(4'b0001 << d)});
          check("frame_seg",   {25'd0, hex_display}, {25'd0, segs[d]});
        end else begin
          check("gap_anode", {28'd0, anode_n}, 32'hF);
          check("gap_seg",   {25'd0, hex_display}, 32'h7F);
        end
      end
    end
  endtask

  // After reset release: two dark cycles, then digit 0 showing the cleared value
  task automatic post_reset_seq();
    step(); check("rst_blank1_anode", {28'd0, anode_n}, 32'hF);
    step(); check("rst_blank2_anode", {28'd0, anode_n}, 32'hF);
    step(); check("rst_digit0_anode", {28'd0, anode_n}, 32'hE);
    check("rst_digit0_seg",   {25'd0, hex_display}, 32'h40);
    check("rst_ready",        {31'd0, load_if.load_ready}, 32'd1);
  endtask

  function automatic vec_t mk(input logic [15:0] v, input logic b,
                              input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0);
    vec_t r;
    r.value = v;
    r.blz   = b;
    r.segs  = {s3, s2, s1, s0};
    return r;
  endfunction

  vec_t vecs[7];
  int   e, t, t1, base;
  int   rise_n;

  initial begin
    vecs[0] = mk(16'h4321, 1'b0, 7'h19, 7'h30, 7'h24, 7'h79);
    vecs[1] = mk(16'h0010, 1'b1, 7'h7F, 7'h7F, 7'h79, 7'h40);
    vecs[2] = mk(16'h0010, 1'b0, 7'h40, 7'h40, 7'h79, 7'h40);
    vecs[3] = mk(16'h0000, 1'b1, 7'h7F, 7'h7F, 7'h7F, 7'h40);
    vecs[4] = mk(16'hABCD, 1'b0, 7'h08, 7'h03, 7'h46, 7'h21);
    vecs[5] = mk(16'h8765, 1'b1, 7'h00, 7'h78, 7'h02, 7'h12);
    vecs[6] = mk(16'hF0E9, 1'b1, 7'h0E, 7'h40, 7'h06, 7'h10);

    reset              = 1'b0;
    enable             = 1'b1;
    blank_lz           = 1'b0;
    load_if.load_valid = 1'b0;
    load_if.load_value = '0;

    // Power-on reset
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_anode", {28'd0, anode_n}, 32'hF);
    check("reset_seg",   {25'd0, hex_display}, 32'h7F);
    check("reset_tick",  {31'd0, frame_tick}, 32'd0);
    check("reset_ready", {31'd0, load_if.load_ready}, 32'd1);
    reset    = 1'b0;
    n        = 0;
    ft_track = 1;
    post_reset_seq();

    // Table: load, then walk the frame in which the value first appears
    for (int i = 0; i < 7; i++) begin
      blank_lz = vecs[i].blz;
      load(vecs[i].value, e);
      t = (e / FRAME + 1) * FRAME;
      check_frame(t, vecs[i].segs);
    end

    // Back-pressure: second value waits until one cycle after frame_tick
    blank_lz = 1'b0;
    load(16'h1111, e);
    t1 = (e / FRAME + 1) * FRAME;
    load_if.load_value = 16'h2222;
    load_if.load_valid = 1'b1;
    rise_n = -1;
    for (int g = 0; g < 200 && rise_n < 0; g++) begin
      if (load_if.load_ready === 1'b1) rise_n = n;
      else begin
        step();
        if (n == t1) check("bp_ready_at_tick", {31'd0, load_if.load_ready}, 32'd0);
      end
    end
    check("bp_ready_rise", rise_n, t1 + 1);
    step();
    load_if.load_valid = 1'b0;
    wait_until(t1 + 4);
    check("bp_first_anode", {28'd0, anode_n}, 32'hE);
    check("bp_first_seg",   {25'd0, hex_display}, 32'h79);
    check_frame(t1 + FRAME, {7'h24, 7'h24, 7'h24, 7'h24});

    // Accept on the frame-end edge: shown two frames later
    t = (n / FRAME + 1) * FRAME;
    wait_until(t - 1);
    load(16'h5555, e);
    check("coincident_edge", e, t);
    check("coincident_tick", {31'd0, frame_tick}, 32'd1);
    check_frame(t, {7'h24, 7'h24, 7'h24, 7'h24});
    check_frame(t + FRAME, {7'h12, 7'h12, 7'h12, 7'h12});

    // enable dropped while digit 1 lit, with a value still pending
    base = n;
    wait_until(base + 8);
    load(16'h7777, e);
    check("en_digit1_anode", {28'd0, anode_n}, 32'hD);
    enable   = 1'b0;
    ft_track = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      check("dis_anode", {28'd0, anode_n}, 32'hF);
      check("dis_seg",   {25'd0, hex_display}, 32'h7F);
      check("dis_tick",  {31'd0, frame_tick}, 32'd0);
      check("dis_ready", {31'd0, load_if.load_ready}, 32'd0);
    end
    enable   = 1'b1;
    n        = 0;
    ft_track = 1;
    step(); check("reen_blank1", {28'd0, anode_n}, 32'hF);
    step(); check("reen_blank2", {28'd0, anode_n}, 32'hF);
    step(); check("reen_anode",  {28'd0, anode_n}, 32'hE);
    check("reen_seg_old",  {25'd0, hex_display}, 32'h12);
    check("reen_pending",  {31'd0, load_if.load_ready}, 32'd0);
    check_frame(FRAME, {7'h78, 7'h78, 7'h78, 7'h78});

    // Reset asserted while digit 2 lit
    wait_until(FRAME * 2 + 16);
    check("pre_reset_anode", {28'd0, anode_n}, 32'hB);
    reset = 1'b1;
    #1;
    check("midon_reset_anode", {28'd0, anode_n}, 32'hF);
    check("midon_reset_seg",   {25'd0, hex_display}, 32'h7F);
    check("midon_reset_tick",  {31'd0, frame_tick}, 32'd0);
    check("midon_reset_ready", {31'd0, load_if.load_ready}, 32'd1);
    @(posedge clk);
    #1;
    check("held_reset_anode", {28'd0, anode_n}, 32'hF);
    reset = 1'b0;
    n     = 0;
    post_reset_seq();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sevenseg_scan_ctrl
`default_nettype wire
